gat_host_loader: RTL

GAT_HOST_LOADER -- requirements
Module: gat_host_loader

---
 rtl/gat_pkg.sv | 39 +++
 rtl/gat_host_loader_if.sv | 12 +
 rtl/gat_feat_reader.sv | 77 +++++++
 rtl/gat_host_loader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/gat_pkg.sv
// rtl/gat_pkg.sv - shared GAT loader types, depth defaults and helpers
package gat_pkg;

    localparam int GAT_TOP_WIDTH         = 32;
    localparam int GAT_H_DATA_DEPTH      = 242101;
    localparam int GAT_NODE_INFO_DEPTH   = 13264;
    localparam int GAT_WEIGHT_DEPTH      = 22928;
    localparam int GAT_NEW_FEATURE_DEPTH = 43328;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_H,
        ST_LOAD_NI,
        ST_LOAD_W,
        ST_WAIT_GAT,
        ST_READ
    } ld_state_e;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_CAP,
        RD_OUT
    } rd_state_e;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_H,
        REG_NI,
        REG_W
    } region_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gat_host_loader_if.sv
// rtl/gat_host_loader_if.sv - word stream bundle used for host load and feature readback
interface gat_host_loader_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gat_feat_reader.sv
// rtl/gat_feat_reader.sv - walks the feature BRAM and streams one word per 3 cycles
module gat_feat_reader
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH = GAT_TOP_WIDTH,
    parameter int DEPTH     = GAT_NEW_FEATURE_DEPTH,
    localparam int AW       = $clog2(DEPTH) + 2,
    localparam int IW       = $clog2(DEPTH)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    output logic                 done_o,
    output logic [AW-1:0]        addrb_o,
    input  logic [TOP_WIDTH-1:0] dout_i,
    gat_host_loader_if.master    m_if
);

    rd_state_e            state_q;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        idx_nxt;
    logic [AW-1:0]        addrb_q;
    logic [TOP_WIDTH-1:0] data_q;
    logic                 valid_q;
    logic                 last_q;
    logic                 done_q;

    assign idx_nxt     = idx_q + 1'b1;
    assign addrb_o     = addrb_q;
    assign done_o      = done_q;
    assign m_if.tdata  = data_q;
    assign m_if.tvalid = valid_q;
    assign m_if.tlast  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RD_IDLE;
            idx_q   <= '0;
            addrb_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                RD_IDLE: if (start_i) begin
                    idx_q   <= '0;
                    addrb_q <= '0;
                    state_q <= RD_ADDR;
                end
                // BRAM samples addrb here; dout is valid during RD_CAP
                RD_ADDR: state_q <= RD_CAP;
                RD_CAP: begin
                    data_q  <= dout_i;
                    valid_q <= 1'b1;
                    last_q  <= (idx_q == IW'(DEPTH - 1));
                    state_q <= RD_OUT;
                end
                RD_OUT: if (m_if.tready) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    if (last_q) begin
                        done_q  <= 1'b1;
                        state_q <= RD_IDLE;
                    end else begin
                        idx_q   <= idx_nxt;
                        addrb_q <= {idx_nxt[AW-3:0], 2'b00};
                        state_q <= RD_ADDR;
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/gat_host_loader.sv
// rtl/gat_host_loader.sv - streams host words into three BRAM regions, then reads features back
module gat_host_loader
    import gat_pkg::*;
#(
    parameter int TOP_WIDTH         = GAT_TOP_WIDTH,
    parameter int H_DATA_DEPTH      = GAT_H_DATA_DEPTH,
    parameter int NODE_INFO_DEPTH   = GAT_NODE_INFO_DEPTH,
    parameter int WEIGHT_DEPTH      = GAT_WEIGHT_DEPTH,
    parameter int NEW_FEATURE_DEPTH = GAT_NEW_FEATURE_DEPTH,
    localparam int H_AW  = $clog2(H_DATA_DEPTH) + 2,
    localparam int NI_AW = $clog2(NODE_INFO_DEPTH) + 2,
    localparam int W_AW  = $clog2(WEIGHT_DEPTH) + 2,
    localparam int F_AW  = $clog2(NEW_FEATURE_DEPTH) + 2
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    gat_host_loader_if.slave     s_if,
    output logic [TOP_WIDTH-1:0] h_data_bram_din,
    output logic                 h_data_bram_ena,
    output logic                 h_data_bram_wea,
    output logic [H_AW-1:0]      h_data_bram_addra,
    output logic [TOP_WIDTH-1:0] h_node_info_bram_din,
    output logic                 h_node_info_bram_ena,
    output logic                 h_node_info_bram_wea,
    output logic [NI_AW-1:0]     h_node_info_bram_addra,
    output logic [TOP_WIDTH-1:0] wgt_bram_din,
    output logic                 wgt_bram_ena,
    output logic                 wgt_bram_wea,
    output logic [W_AW-1:0]      wgt_bram_addra,
    output logic                 h_data_bram_load_done,
    output logic                 h_node_info_bram_load_done,
    output logic                 wgt_bram_load_done,
    input  logic                 gat_ready,
    output logic [F_AW-1:0]      feat_bram_addrb,
    input  logic [TOP_WIDTH-1:0] feat_bram_dout,
    gat_host_loader_if.master    m_if,
    output logic                 busy,
    output logic                 done
);

    localparam int IW = $clog2(max3(H_DATA_DEPTH, NODE_INFO_DEPTH, WEIGHT_DEPTH));

    ld_state_e            state_q;
    region_e              wr_region;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        depth_m1;
    logic [IW-1:0]        wr_idx_q;
    logic [TOP_WIDTH-1:0] wr_din_q;
    logic                 h_ena_q, ni_ena_q, w_ena_q;
    logic                 h_done_q, ni_done_q, w_done_q;
    logic                 rd_start_q;
    logic                 rd_done;
    logic                 hs;
    logic                 unused_tlast;

    always_comb begin
        wr_region = REG_NONE;
        depth_m1  = '0;
        case (state_q)
            ST_LOAD_H:  begin wr_region = REG_H;  depth_m1 = IW'(H_DATA_DEPTH - 1);    end
            ST_LOAD_NI: begin wr_region = REG_NI; depth_m1 = IW'(NODE_INFO_DEPTH - 1); end
            ST_LOAD_W:  begin wr_region = REG_W;  depth_m1 = IW'(WEIGHT_DEPTH - 1);    end
            default:    ;
        endcase
    end

    assign s_if.tready  = (wr_region != REG_NONE);
    assign hs           = s_if.tvalid && s_if.tready;
    assign unused_tlast = s_if.tlast;

    // One shared din/index register; only the strobed region's ena qualifies it
    assign h_data_bram_din        = wr_din_q;
    assign h_data_bram_ena        = h_ena_q;
    assign h_data_bram_wea        = h_ena_q;
    assign h_data_bram_addra      = {wr_idx_q[H_AW-3:0], 2'b00};
    assign h_node_info_bram_din   = wr_din_q;
    assign h_node_info_bram_ena   = ni_ena_q;
    assign h_node_info_bram_wea   = ni_ena_q;
    assign h_node_info_bram_addra = {wr_idx_q[NI_AW-3:0], 2'b00};
    assign wgt_bram_din           = wr_din_q;
    assign wgt_bram_ena           = w_ena_q;
    assign wgt_bram_wea           = w_ena_q;
    assign wgt_bram_addra         = {wr_idx_q[W_AW-3:0], 2'b00};

    assign h_data_bram_load_done      = h_done_q;
    assign h_node_info_bram_load_done = ni_done_q;
    assign wgt_bram_load_done         = w_done_q;
    assign busy                       = (state_q != ST_IDLE);
    assign done                       = rd_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            wr_idx_q   <= '0;
            wr_din_q   <= '0;
            h_ena_q    <= 1'b0;
            ni_ena_q   <= 1'b0;
            w_ena_q    <= 1'b0;
            h_done_q   <= 1'b0;
            ni_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rd_start_q <= 1'b0;
        end else begin
            h_ena_q    <= hs && (wr_region == REG_H);
            ni_ena_q   <= hs && (wr_region == REG_NI);
            w_ena_q    <= hs && (wr_region == REG_W);
            rd_start_q <= 1'b0;
            // A strobe seen after the FSM left that region's state was its final word
            if (h_ena_q  && state_q != ST_LOAD_H)  h_done_q  <= 1'b1;
            if (ni_ena_q && state_q != ST_LOAD_NI) ni_done_q <= 1'b1;
            if (w_ena_q  && state_q != ST_LOAD_W)  w_done_q  <= 1'b1;
            if (hs) begin
                wr_din_q <= s_if.tdata;
                wr_idx_q <= idx_q;
            end
            case (state_q)
                ST_IDLE: if (start) begin
                    idx_q     <= '0;
                    h_done_q  <= 1'b0;
                    ni_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    state_q   <= ST_LOAD_H;
                end
                ST_LOAD_H, ST_LOAD_NI, ST_LOAD_W: if (hs) begin
                    if (idx_q == depth_m1) begin
                        idx_q   <= '0;
                        state_q <= (state_q == ST_LOAD_H)  ? ST_LOAD_NI :
                                   (state_q == ST_LOAD_NI) ? ST_LOAD_W  : ST_WAIT_GAT;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_WAIT_GAT: if (gat_ready) begin
                    rd_start_q <= 1'b1;
                    state_q    <= ST_READ;
                end
                ST_READ: if (rd_done) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    gat_feat_reader #(
        .TOP_WIDTH (TOP_WIDTH),
        .DEPTH     (NEW_FEATURE_DEPTH)
    ) u_reader (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (rd_start_q),
        .done_o  (rd_done),
        .addrb_o (feat_bram_addrb),
        .dout_i  (feat_bram_dout),
        .m_if    (m_if)
    );

endmodule
